// File: rtl/spi_slave_responder.sv
// SPI responder: synchronises SCLK/CS_n/MOSI into clk and shifts
// LSB-first frames, with one-entry TX buffer and RX holding register.
module spi_slave_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              underrun
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   cs_dly_q, cs_dly_d;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;

    // Shift pins through the synchroniser chains and edge-delay flops
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_dly_d  = sclk_s;
        cs_dly_d    = cs_s;
    end

    // Frame FSM, shift register, TX buffer and RX holding register
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        overrun_d  = 1'b0;
        underrun_d = 1'b0;

        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    if (tx_full_q) begin
                        sreg_d    = tx_buf_q;
                        tx_full_d = 1'b0;
                    end else begin
                        sreg_d     = '0;
                        underrun_d = 1'b1;
                    end
                    miso_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (sclk_rise) begin
                    miso_d = sreg_q[0];
                    sreg_d = sreg_q >> 1;
                end else if (sclk_fall) begin
                    if (cnt_q == LAST) begin
                        rx_data_d  = {mosi_s, sreg_q[DATA_W-2:0]};
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q && !rx_ready;
                        cnt_d      = '0;
                        if (tx_full_q) begin
                            sreg_d    = tx_buf_q;
                            tx_full_d = 1'b0;
                        end else begin
                            sreg_d     = '0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        sreg_d[DATA_W-1] = mosi_s;
                        cnt_d            = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register all state; chip select idles high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_dly_q    <= cs_dly_d;
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ready = ~tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule
